hls_mul_pipe_sat: RTL and testbench

- Parametrised, pipelined integer multiplier for HLS-generated datapaths; next generation of the single-cycle combinational `*_mul_*` cores.
- Adds a configurable pipeline depth, a valid/ready handshake with backpressure, and a signed/unsigned mode.
- Adds a saturating or wrapping output-narrowing mode with an overflow flag.
- Sits between scheduled operand registers and consumers that may stall (FIFOs, stream writers).

---
 rtl/hls_arith_pkg.sv | 43 ++++
 rtl/hls_pipe_stage.sv | 38 +++
 rtl/hls_mul_pipe_sat.sv | 97 +++++++++
 tb/tb_hls_mul_pipe_sat.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_arith_pkg.sv
// Shared arithmetic helpers for HLS datapath cores: width helpers, parameter
// legality and the narrow/saturate function used on full-width products.
package hls_arith_pkg;

  // Products are carried at this width before narrowing; operands must fit below it.
  localparam int VALUE_W = 64;

  typedef struct packed {
    logic [VALUE_W-1:0] value;
    logic               ovf;
  } narrow_t;

  function automatic int PROD_W(input int a, input int b);
    return a + b;
  endfunction

  function automatic bit params_ok(input int num_stage, input int a_w, input int b_w,
                                   input int dout_w);
    return (num_stage >= 1) && (num_stage <= 6) && (a_w >= 1) && (b_w >= 1) &&
           (dout_w >= 2) && (dout_w <= PROD_W(a_w, b_w)) && (PROD_W(a_w, b_w) < VALUE_W);
  endfunction

  // value is the exact product, sign- or zero-extended to VALUE_W by the caller.
  function automatic narrow_t narrow(input logic signed [VALUE_W-1:0] value, input int width,
                                     input logic is_signed, input logic saturate);
    logic signed [VALUE_W-1:0] hi;
    logic signed [VALUE_W-1:0] lo;
    narrow_t                   r;
    if (is_signed) begin
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
    end else begin
      hi = (64'sd1 <<< width) - 64'sd1;
      lo = '0;
    end
    r.ovf = (value > hi) || (value < lo);
    if (saturate && (value > hi))      r.value = hi;
    else if (saturate && (value < lo)) r.value = lo;
    else                               r.value = value;
    return r;
  endfunction

endpackage

// File: rtl/hls_pipe_stage.sv
// One pipeline register: a valid bit cleared by reset plus a data word, both
// loaded together when en is high and held otherwise.
module hls_pipe_stage #(
  parameter int WIDTH      = 1,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // NOTE: registers use non-blocking assignment so every stage samples its
  // neighbour's pre-edge value and the chain shifts by exactly one per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  valid <= 1'b0;
    else if (en) valid <= load_valid;
  end

  generate
    if (CLEAR_DATA) begin : g_clear
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  data <= '0;
        else if (en) data <= load_data;
      end
    end else begin : g_hold
      // NOTE: data behind a valid bit needs no reset; the cleared valid already
      // marks it meaningless, and leaving it unreset keeps the flops cheaper.
      always_ff @(posedge clk) begin
        if (en) data <= load_data;
      end
    end
  endgenerate

endmodule

// File: rtl/hls_mul_pipe_sat.sv
// Pipelined integer multiplier with valid/ready handshake, global stall and
// saturating or wrapping narrowing of the full-width product.
module hls_mul_pipe_sat
  import hls_arith_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 12,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 12,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf,
  output logic                  busy
);

  localparam int PW = PROD_W(din0_WIDTH, din1_WIDTH);
  localparam int DW = dout_WIDTH + 1;

  generate
    if (!params_ok(NUM_STAGE, din0_WIDTH, din1_WIDTH, dout_WIDTH)) begin : g_bad_params
      $error("hls_mul_pipe_sat: illegal NUM_STAGE/width parameters (product width %0d)", PW);
    end
  endgenerate

  logic                      advance;
  logic                      accept;
  logic signed [VALUE_W-1:0] prod;
  narrow_t                   nar;
  logic [DW-1:0]             stage0_data;
  logic [NUM_STAGE-1:0]      valid;
  logic [DW-1:0]             data [NUM_STAGE];

  // Whole pipe advances or holds as one; in_ready never looks at in_valid.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  generate
    if (SIGNED != 0) begin : g_signed
      assign prod = VALUE_W'($signed(din0)) * VALUE_W'($signed(din1));
    end else begin : g_unsigned
      assign prod = VALUE_W'(din0) * VALUE_W'(din1);
    end
  endgenerate

  assign nar         = narrow(prod, dout_WIDTH, SIGNED != 0, SATURATE != 0);
  assign stage0_data = {nar.value[dout_WIDTH-1:0], nar.ovf};

  generate
    for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
      logic          load_valid;
      logic [DW-1:0] load_data;
      if (i == 0) begin : g_first
        assign load_valid = accept;
        assign load_data  = stage0_data;
      end else begin : g_next
        assign load_valid = valid[i-1];
        assign load_data  = data[i-1];
      end
      hls_pipe_stage #(
        .WIDTH     (DW),
        .CLEAR_DATA(i == NUM_STAGE - 1)
      ) u_stage (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .en        (advance),
        .load_valid(load_valid),
        .load_data (load_data),
        .valid     (valid[i]),
        .data      (data[i])
      );
    end
  endgenerate

  assign out_valid = valid[NUM_STAGE-1];
  assign dout      = data[NUM_STAGE-1][DW-1:1];
  assign ovf       = data[NUM_STAGE-1][0];
  assign busy      = |valid;

  // Bits above dout_WIDTH and the instance tag are intentionally dropped.
  logic [VALUE_W-dout_WIDTH-1:0] unused_hi;
  logic [31:0]                   unused_id;
  assign unused_hi = nar.value[VALUE_W-1:dout_WIDTH];
  assign unused_id = ID;

endmodule

// File: tb/tb_hls_mul_pipe_sat.sv
// Bench for hls_mul_pipe_sat: three parameter variants share one stimulus
// stream; a queue-based product model is compared on every output handshake.
module tb_hls_mul_pipe_sat;

  // Per-instance modes: bit k belongs to dut k.
  localparam logic [2:0] SGN = 3'b011;
  localparam logic [2:0] SAT = 3'b101;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [11:0] din0;
  logic [11:0] din1;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  ovf;
  logic [2:0]  busy;
  logic [11:0] dout [3];

  int errors = 0;
  int checks = 0;

  logic [12:0] exp_q [3][$];
  logic [12:0] held [3];
  bit          held_v [3];

  always #5 ap_clk = ~ap_clk;

  hls_mul_pipe_sat u_dut0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .din0(din0), .din1(din1), .out_valid(out_valid[0]), .out_ready(out_ready),
    .dout(dout[0]), .ovf(ovf[0]), .busy(busy[0])
  );

  hls_mul_pipe_sat #(.SATURATE(0)) u_dut1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .din0(din0), .din1(din1), .out_valid(out_valid[1]), .out_ready(out_ready),
    .dout(dout[1]), .ovf(ovf[1]), .busy(busy[1])
  );

  hls_mul_pipe_sat #(.SIGNED(0), .SATURATE(1)) u_dut2 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .din0(din0), .din1(din1), .out_valid(out_valid[2]), .out_ready(out_ready),
    .dout(dout[2]), .ovf(ovf[2]), .busy(busy[2])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Exact product in plain integers, then clamp or wrap into 12 bits.
  function automatic logic [12:0] model(input logic [11:0] a, input logic [11:0] b,
                                        input bit sgn, input bit sat);
    longint      p, hi, lo, r;
    logic [63:0] rb;
    if (sgn) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      hi = 2047;
      lo = -2048;
    end else begin
      p  = longint'(a) * longint'(b);
      hi = 4095;
      lo = 0;
    end
    r = p;
    if (sat && p > hi)      r = hi;
    else if (sat && p < lo) r = lo;
    rb = r;
    return {rb[11:0], (p > hi) || (p < lo)};
  endfunction

  // Compare process: handshake rules, stall hold, and in-order results.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int k = 0; k < 3; k++) begin
        exp_q[k].delete();
        held_v[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("d%0d_in_ready", k), in_ready[k], !(out_valid[k] && !out_ready));
        if (held_v[k]) begin
          check($sformatf("d%0d_hold_valid", k), out_valid[k], 1);
          check($sformatf("d%0d_hold_data", k), {dout[k], ovf[k]}, held[k]);
        end
        if (out_valid[k] && out_ready) begin
          if (exp_q[k].size() == 0) check($sformatf("d%0d_extra_out", k), out_valid[k], 0);
          else check($sformatf("d%0d_result", k), {dout[k], ovf[k]}, exp_q[k].pop_front());
        end
        held_v[k] = out_valid[k] && !out_ready;
        held[k]   = {dout[k], ovf[k]};
        if (in_valid && in_ready[k]) exp_q[k].push_back(model(din0, din1, SGN[k], SAT[k]));
      end
    end
  end

  // Called mid-cycle with out_ready high and the pipe empty; returns latency in cycles.
  task automatic drive_and_wait(input logic [11:0] a, input logic [11:0] b, output int lat);
    din0     = a;
    din1     = b;
    in_valid = 1'b1;
    lat      = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge ap_clk);
      if (c == 1) begin
        #1;
        in_valid = 1'b0;
      end
      @(negedge ap_clk);
      if (out_valid[0]) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) check("op_timeout", out_valid[0], 1);
  endtask

  task automatic run_op(input logic [11:0] a, input logic [11:0] b, output int lat);
    @(posedge ap_clk);
    #1;
    drive_and_wait(a, b, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          idx;
    int          cyc;
    int          stalls;
    bit          acc;
    logic [11:0] got [$];

    in_valid  = 1'b0;
    out_ready = 1'b1;
    din0      = '0;
    din1      = '0;
    ap_rst_n  = 1'b0;

    repeat (2) @(posedge ap_clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("d%0d_rst_out_valid", k), out_valid[k], 0);
      check($sformatf("d%0d_rst_busy", k), busy[k], 0);
      check($sformatf("d%0d_rst_dout", k), dout[k], 0);
      check($sformatf("d%0d_rst_ovf", k), ovf[k], 0);
      check($sformatf("d%0d_rst_in_ready", k), in_ready[k], 1);
    end
    #2;
    ap_rst_n = 1'b1;

    // -5 * 7
    run_op(12'hFFB, 12'h007, lat);
    check("latency_m5x7", lat, 3);
    check("d0_m5x7", {dout[0], ovf[0]}, {12'hFDD, 1'b0});
    check("d1_m5x7", {dout[1], ovf[1]}, {12'hFDD, 1'b0});

    run_op(12'd100, 12'd100, lat);
    check("d0_100x100", {dout[0], ovf[0]}, {12'h7FF, 1'b1});
    check("d1_100x100_wrap", {dout[1], ovf[1]}, {12'h710, 1'b1});
    check("d2_100x100_uns", {dout[2], ovf[2]}, {12'hFFF, 1'b1});

    run_op(12'hF9C, 12'd100, lat);
    check("d0_m100x100", {dout[0], ovf[0]}, {12'h800, 1'b1});

    run_op(12'h800, 12'h800, lat);
    check("d0_min_x_min", {dout[0], ovf[0]}, {12'h7FF, 1'b1});

    run_op(12'd3, 12'd4, lat);
    check("d1_3x4_wrap", {dout[1], ovf[1]}, {12'h00C, 1'b0});

    run_op(12'hFFF, 12'h001, lat);
    check("d2_4095x1", {dout[2], ovf[2]}, {12'hFFF, 1'b0});
    check("d0_m1x1", {dout[0], ovf[0]}, {12'hFFF, 1'b0});

    run_op(12'hFFF, 12'h002, lat);
    check("d2_4095x2", {dout[2], ovf[2]}, {12'hFFF, 1'b1});

    run_op(12'h000, 12'hFFF, lat);
    check("d2_0x4095", {dout[2], ovf[2]}, {12'h000, 1'b0});

    // Backpressure: continuous stream 1..10, out_ready low for cycles 5-8.
    @(posedge ap_clk);
    #1;
    idx      = 1;
    cyc      = 0;
    stalls   = 0;
    din0     = 12'd1;
    din1     = 12'd1;
    in_valid = 1'b1;
    while (got.size() < 10 && cyc < 60) begin
      @(negedge ap_clk);
      acc = in_valid && in_ready[0];
      if (out_valid[0] && out_ready)  got.push_back(dout[0]);
      if (out_valid[0] && !out_ready) stalls++;
      @(posedge ap_clk);
      #1;
      cyc++;
      if (acc) begin
        idx++;
        if (idx > 10) in_valid = 1'b0;
        else          din0 = 12'(idx);
      end
      out_ready = !(cyc >= 5 && cyc <= 8);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", got.size(), 10);
    check("bp_stall_cycles", stalls, 4);
    for (int i = 0; i < got.size(); i++) check($sformatf("bp_item%0d", i), got[i], i + 1);

    // Reset with three operations in flight.
    repeat (2) @(posedge ap_clk);
    #1;
    in_valid = 1'b1;
    din1     = 12'd1;
    din0     = 12'd7;
    @(posedge ap_clk);
    #1;
    din0 = 12'd8;
    @(posedge ap_clk);
    #1;
    din0 = 12'd9;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    check("inflight_busy", busy[0], 1);
    check("inflight_out_valid", out_valid[0], 1);
    #1;
    ap_rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("d%0d_midrst_out_valid", k), out_valid[k], 0);
      check($sformatf("d%0d_midrst_busy", k), busy[k], 0);
      check($sformatf("d%0d_midrst_dout", k), dout[k], 0);
      check($sformatf("d%0d_midrst_in_ready", k), in_ready[k], 1);
    end
    repeat (2) @(posedge ap_clk);
    #3;
    ap_rst_n = 1'b1;
    drive_and_wait(12'd2, 12'd3, lat);
    check("post_rst_latency", lat, 3);
    check("post_rst_2x3", {dout[0], ovf[0]}, {12'h006, 1'b0});

    repeat (4) @(posedge ap_clk);
    @(negedge ap_clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("d%0d_drained_busy", k), busy[k], 0);
      check($sformatf("d%0d_queue_empty", k), exp_q[k].size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
